// File: rtl/iterative_mul_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit.
// The multiplier is a radix-2^MUL_STEP shift-add iterator. The divider is a
// 1-bit/cycle restoring divider. Both work on operand magnitudes. A single
// FIXUP cycle applies the sign correction, adds or subtracts for the MADD and
// MSUB families, and commits {hi,lo}.
module iterative_mul_div_unit #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [3:0]       operation,
  input  logic             start,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] dataRead
);

  localparam logic [3:0] OP_RD_HI = 4'd0;
  localparam logic [3:0] OP_RD_LO = 4'd1;
  localparam logic [3:0] OP_WR_HI = 4'd2;
  localparam logic [3:0] OP_WR_LO = 4'd3;
  localparam logic [3:0] OP_MUL   = 4'd4;
  localparam logic [3:0] OP_MULU  = 4'd5;
  localparam logic [3:0] OP_DIV   = 4'd6;
  localparam logic [3:0] OP_DIVU  = 4'd7;
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
  localparam logic [3:0] OP_MSUBU = 4'd11;

  localparam int MUL_ITERS = WIDTH / MUL_STEP;
  localparam int CNT_W     = $clog2(WIDTH + 1);
  localparam int PW        = WIDTH + MUL_STEP;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_ITER = 2'd1,
    DIV_ITER = 2'd2,
    FIXUP    = 2'd3
  } state_t;

  state_t state, state_next;

  // Architectural registers
  logic [WIDTH-1:0] hi, lo;

  // Latched command
  logic [3:0]       op_q;
  logic             sign_a, sign_b, dbz;
  logic [CNT_W-1:0] count;

  // Iteration datapath
  logic [WIDTH-1:0]   mcand, divisor, quo, rem;
  logic [2*WIDTH-1:0] prod;

  // Decode / control
  logic             is_mul_op, is_div_op, signed_op;
  logic             load_cmd, wr_hi, wr_lo, commit;
  logic             sign1, sign2;
  logic [WIDTH-1:0] mag1, mag2;

  // Step and fixup results
  logic [MUL_STEP-1:0]         mul_digit;
  logic [PW-1:0]               mul_sum;
  logic [2*WIDTH+MUL_STEP-1:0] mul_wide;
  logic [2*WIDTH-1:0]          prod_next;
  logic [WIDTH:0]              div_shift, div_diff;
  logic [WIDTH-1:0]            rem_next, quo_next;
  logic [2*WIDTH-1:0]          prod_fix, result;
  logic [WIDTH-1:0]            quo_fix, rem_fix;

  // Two's-complement negate of a WIDTH-bit value when neg is set
  function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v, input logic neg);
    logic [WIDTH-1:0] r;
    r = v;
    if (neg) r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    return r;
  endfunction

  // Two's-complement negate of a 2*WIDTH-bit value when neg is set
  function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    logic [2*WIDTH-1:0] r;
    r = v;
    if (neg) r = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    return r;
  endfunction

  // Classify the incoming operation code
  always_comb begin
    is_mul_op = 1'b0;
    is_div_op = 1'b0;
    case (operation)
      OP_MUL, OP_MULU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul_op = 1'b1;
      OP_DIV, OP_DIVU:                                       is_div_op = 1'b1;
      default: ;
    endcase
  end

  // Even codes in the arithmetic range are the signed variants
  assign signed_op = ~operation[0];
  assign sign1     = signed_op & operand1[WIDTH-1];
  assign sign2     = signed_op & operand2[WIDTH-1];
  assign mag1      = negate_w(operand1, sign1);
  assign mag2      = negate_w(operand2, sign2);

  // Shift-add multiply step: retire MUL_STEP multiplier bits from prod's low half
  assign mul_digit = prod[MUL_STEP-1:0];
  assign mul_sum   = PW'(prod[2*WIDTH-1:WIDTH]) + PW'(mcand) * PW'(mul_digit);
  assign mul_wide  = {mul_sum, prod[WIDTH-1:0]};
  assign prod_next = mul_wide[2*WIDTH+MUL_STEP-1:MUL_STEP];

  // Restoring divide step: shift in the next dividend bit, keep the
  // difference only when it did not go negative
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, divisor};
  assign rem_next  = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign quo_next  = {quo[WIDTH-2:0], ~div_diff[WIDTH]};

  // Sign correction and accumulate for the commit in FIXUP
  always_comb begin
    prod_fix = negate_2w(prod, sign_a ^ sign_b);
    quo_fix  = negate_w(quo, sign_a ^ sign_b);
    rem_fix  = negate_w(rem, sign_a);
    result   = prod_fix;
    case (op_q)
      OP_MADD, OP_MADDU: result = {hi, lo} + prod_fix;
      OP_MSUB, OP_MSUBU: result = {hi, lo} - prod_fix;
      OP_DIV, OP_DIVU:   result = {rem_fix, quo_fix};
      default:           result = prod_fix;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state and per-cycle control strobes
  always_comb begin
    state_next = state;
    load_cmd   = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (operation == OP_WR_HI) begin
            wr_hi = 1'b1;
          end else if (operation == OP_WR_LO) begin
            wr_lo = 1'b1;
          end else if (is_mul_op) begin
            load_cmd   = 1'b1;
            state_next = MUL_ITER;
          end else if (is_div_op) begin
            load_cmd   = 1'b1;
            state_next = (operand2 == '0) ? FIXUP : DIV_ITER;
          end
        end
      end
      MUL_ITER, DIV_ITER: begin
        if (cancel)                       state_next = IDLE;
        else if (count == CNT_W'(1))      state_next = FIXUP;
      end
      FIXUP: begin
        state_next = IDLE;
        commit     = ~cancel;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command latch and iteration datapath
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q    <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      dbz     <= 1'b0;
      count   <= '0;
      mcand   <= '0;
      divisor <= '0;
      quo     <= '0;
      rem     <= '0;
      prod    <= '0;
    end else if (load_cmd) begin
      op_q    <= operation;
      sign_a  <= sign1;
      sign_b  <= sign2;
      dbz     <= is_div_op & (operand2 == '0);
      count   <= is_mul_op ? CNT_W'(MUL_ITERS) : CNT_W'(WIDTH);
      mcand   <= mag1;
      divisor <= mag2;
      quo     <= mag1;
      rem     <= '0;
      prod    <= {{WIDTH{1'b0}}, mag2};
    end else if (state == MUL_ITER) begin
      prod  <= prod_next;
      count <= count - CNT_W'(1);
    end else if (state == DIV_ITER) begin
      rem   <= rem_next;
      quo   <= quo_next;
      count <= count - CNT_W'(1);
    end
  end

  // HI/LO: direct writes from IDLE, otherwise the FIXUP commit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (wr_hi) begin
      hi <= operand1;
    end else if (wr_lo) begin
      lo <= operand1;
    end else if (commit && !dbz) begin
      hi <= result[2*WIDTH-1:WIDTH];
      lo <= result[WIDTH-1:0];
    end
  end

  // Completion pulse one cycle after the commit edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done      <= 1'b0;
      divByZero <= 1'b0;
    end else begin
      done      <= commit;
      divByZero <= commit & dbz;
    end
  end

  assign busy = (state != IDLE);

  // Read port always shows committed HI/LO
  always_comb begin
    dataRead = '0;
    if (operation == OP_RD_HI)      dataRead = hi;
    else if (operation == OP_RD_LO) dataRead = lo;
  end

endmodule

// File: tb/tb_iterative_mul_div_unit.sv
// Scoreboard bench for iterative_mul_div_unit (WIDTH=32, MUL_STEP=4).
// The driver issues commands and pushes expected busy lengths, done events and
// read values into queues; a monitor pops and compares whenever the DUT shows
// busy falling, a done pulse, or a requested read.
module tb_iterative_mul_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic [3:0]  operation = 4'd4;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic        busy, done, divByZero;
  logic [31:0] dataRead;

  logic        rd_vld = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  logic [31:0] rd_q[$];
  logic        done_q[$];
  int          lat_q[$];

  iterative_mul_div_unit #(.WIDTH(32), .MUL_STEP(4)) dut (
    .clock(clock), .reset(reset), .operand1(operand1), .operand2(operand2),
    .operation(operation), .start(start), .cancel(cancel), .busy(busy),
    .done(done), .divByZero(divByZero), .dataRead(dataRead)
  );

  always #5 clock = ~clock;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] pick_op();
    int r;
    r = $urandom_range(0, 19);
    if (r < 16)      return 4'(4 + (r % 8));
    else if (r < 18) return 4'(2 + (r % 2));
    else if (r == 18) return 4'($urandom_range(0, 1));
    else             return 4'($urandom_range(12, 15));
  endfunction

  // Issue one command, compute its architectural effect, and follow it to completion
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int cancel_at, input bit junk, input bit idle_cancel);
    logic [63:0] res, p, hilo;
    longint      sa, sb;
    bit          computes, dbz, cancelled;
    int          len, cyc;
    computes = 0; dbz = 0; len = 0;
    hilo = {hi_m, lo_m};
    res  = hilo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11: begin
        computes = 1; len = 9;
        p = op[0] ? ({32'h0, a} * {32'h0, b}) : 64'(sa * sb);
        if (op == 4'd4 || op == 4'd5)      res = p;
        else if (op == 4'd8 || op == 4'd9) res = hilo + p;
        else                               res = hilo - p;
      end
      4'd6, 4'd7: begin
        computes = 1;
        if (b == 32'h0) begin
          dbz = 1; len = 1;
        end else begin
          len = 33;
          if (op == 4'd6) res = {32'(sa % sb), 32'(sa / sb)};
          else            res = {a % b, a / b};
        end
      end
      default: ;
    endcase
    cancelled = computes && cancel_at >= 1 && cancel_at <= len;
    if (computes) lat_q.push_back(cancelled ? cancel_at : len);
    if (computes && !cancelled) done_q.push_back(dbz);

    @(posedge clock); #1;
    operation = op; operand1 = a; operand2 = b; start = 1'b1; cancel = idle_cancel; rd_vld = 1'b0;
    @(posedge clock); #1;
    start = 1'b0; cancel = 1'b0;
    if (op == 4'd2) hi_m = a;
    if (op == 4'd3) lo_m = a;
    cyc = 1;
    while (busy === 1'b1 && cyc <= 60) begin
      start = 1'b0; cancel = 1'b0; rd_vld = 1'b0;
      if (cyc == cancel_at) begin
        cancel = 1'b1;
      end else if (junk) begin
        if (cyc == 3) begin
          start = 1'b1; operation = 4'd2; operand1 = 32'h1234;
        end else begin
          case ($urandom_range(0, 3))
            1: begin start = 1'b1; operation = 4'($urandom_range(0, 15)); operand1 = $urandom; operand2 = $urandom; end
            2: begin operation = 4'd0; start = 1'($urandom_range(0, 1)); rd_vld = 1'b1; rd_q.push_back(hi_m); end
            3: begin operation = 4'd1; start = 1'($urandom_range(0, 1)); rd_vld = 1'b1; rd_q.push_back(lo_m); end
            default: ;
          endcase
        end
      end
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0; cancel = 1'b0; rd_vld = 1'b0;
    if (busy === 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL busy_timeout: busy still 1 after 60 cycles, expected 0");
    end
    if (computes && !cancelled && !dbz) {hi_m, lo_m} = res;

    operation = 4'd0; rd_vld = 1'b1; rd_q.push_back(hi_m);
    @(posedge clock); #1;
    operation = 4'd1; rd_q.push_back(lo_m);
    @(posedge clock); #1;
    operation = 4'($urandom_range(2, 15)); rd_q.push_back(32'h0);
    @(posedge clock); #1;
    rd_vld = 1'b0; operation = 4'd4;
  endtask

  // Async reset in the middle of a multiply
  task automatic reset_mid_mul();
    run_op(4'd2, 32'hCAFE_0001, 32'h0, 0, 0, 0);
    run_op(4'd3, 32'h0000_BEEF, 32'h0, 0, 0, 0);
    @(posedge clock); #1;
    operation = 4'd5; operand1 = 32'h1234_5678; operand2 = 32'h9; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    lat_q.push_back(4);
    reset = 1'b0;
    #1;
    check("busy_after_reset", {63'h0, busy}, 64'h0);
    check("done_after_reset", {63'h0, done}, 64'h0);
    operation = 4'd0; rd_vld = 1'b1; rd_q.push_back(32'h0);
    @(posedge clock); #1;
    operation = 4'd1; rd_q.push_back(32'h0);
    @(posedge clock); #1;
    rd_vld = 1'b0; operation = 4'd4;
    reset = 1'b1;
    hi_m = '0; lo_m = '0;
  endtask

  // Monitor: compare busy run lengths, done pulses and requested reads
  initial begin : monitor
    int          busy_run;
    logic [31:0] exp_rd;
    logic        exp_dbz;
    busy_run = 0;
    forever begin
      @(negedge clock);
      if (busy === 1'b1) begin
        busy_run++;
      end else if (busy_run > 0) begin
        if (lat_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL busy_len: got %0d busy cycles, expected none", busy_run);
        end else begin
          check("busy_len", 64'(busy_run), 64'(lat_q.pop_front()));
        end
        busy_run = 0;
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL done: got done=1, expected 0");
        end else begin
          exp_dbz = done_q.pop_front();
          check("divByZero", {63'h0, divByZero}, {63'h0, exp_dbz});
        end
      end
      if (rd_vld) begin
        if (rd_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL read: got 0x%0h with no expectation, expected none", dataRead);
        end else begin
          exp_rd = rd_q.pop_front();
          check("dataRead", {32'h0, dataRead}, {32'h0, exp_rd});
        end
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Driver
  initial begin : driver
    logic [3:0]  op;
    logic [31:0] a, b;
    int          ca;
    repeat (2) @(posedge clock);
    #1;
    check("busy_reset", {63'h0, busy}, 64'h0);
    check("done_reset", {63'h0, done}, 64'h0);
    check("dbz_reset", {63'h0, divByZero}, 64'h0);
    operation = 4'd0; rd_vld = 1'b1; rd_q.push_back(32'h0);
    @(posedge clock); #1;
    operation = 4'd1; rd_q.push_back(32'h0);
    @(posedge clock); #1;
    rd_vld = 1'b0; operation = 4'd4;
    reset = 1'b1;

    run_op(4'd4,  32'hFFFF_FFFF, 32'h0000_0002, 0, 0, 0);
    run_op(4'd5,  32'hFFFF_FFFF, 32'h0000_0002, 0, 0, 0);
    run_op(4'd9,  32'h1, 32'h1, 0, 0, 0);
    run_op(4'd6,  32'hFFFF_FFF9, 32'h2, 0, 0, 0);
    run_op(4'd7,  32'h7, 32'h0, 0, 0, 0);
    run_op(4'd6,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    run_op(4'd2,  32'h0, 32'h0, 0, 0, 0);
    run_op(4'd3,  32'h5, 32'h0, 0, 0, 0);
    run_op(4'd10, 32'h3, 32'h4, 0, 0, 0);
    run_op(4'd6,  32'd100, 32'd7, 10, 1, 0);
    run_op(4'd4,  32'd5, 32'd6, 0, 1, 1);
    run_op(4'd9,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, 0, 0);
    reset_mid_mul();

    for (int i = 0; i < 80; i++) begin
      op = pick_op();
      a  = pick_val();
      b  = pick_val();
      ca = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 34) : 0;
      run_op(op, a, b, ca, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    repeat (4) @(posedge clock);
    #1;
    check("done_q_drained", 64'(done_q.size()), 64'h0);
    check("lat_q_drained", 64'(lat_q.size()), 64'h0);
    check("rd_q_drained", 64'(rd_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
